bt_cmd_seq: RTL



---
 rtl/bt_pkg.sv | 31 +++
 rtl/bt_req_arb.sv | 50 +++++
 rtl/bt_cmd_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth command sequencer.
// Holds the sequencer state type, the default command ROM addresses and
// lengths, and a width helper that never returns a zero width.
package bt_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        BOOT,
        INIT_SEND,
        INIT_WAIT,
        IDLE,
        BTN_SEND,
        BTN_WAIT,
        FAIL
    } state_t;

    // Default command ROM layout
    localparam int unsigned INIT0_START = 0;
    localparam int unsigned INIT0_LEN   = 6;
    localparam int unsigned INIT1_START = 6;
    localparam int unsigned INIT1_LEN   = 10;
    localparam int unsigned CMD_NEXT    = 16;
    localparam int unsigned CMD_PREV    = 20;
    localparam int unsigned CMD_BTN_LEN = 4;

    // Counter width for a limit, at least one bit
    function automatic int unsigned width_of(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/bt_req_arb.sv
// Button request register with fixed-priority pick.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   btn_rel     release pulses, one bit per button
//   set_en      pulses are captured only while this is high
//   take        consume the currently granted request this cycle
//   pend_any    at least one request pending
//   gnt_idx     index of the lowest-numbered pending request
module bt_req_arb #(
    parameter int unsigned NUM_BTN = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_rel,
    input  logic               set_en,
    input  logic               take,
    output logic               pend_any,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] gnt;
    logic               found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (pend[i] && !found) begin
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign pend_any = |pend;

    // Clear is applied before set so a new pulse on the granted bit survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~(take ? gnt : '0)) | (set_en ? btn_rel : '0);
        end
    end

endmodule

// File: rtl/bt_cmd_seq.sv
// Command sequencer for the Bluetooth audio module.
// Holds the module in reset for PWRUP_CYC cycles, waits for its boot prompt,
// plays the init command table, then turns button releases into commands.
// Every command is re-sent on response timeout up to MAX_RETRY times.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   btn_rel      button release pulses (bit i = button i)
//   resp_rcvd    response pulse from snd_cmd
//   cmd_n        module reset pin, 1 = held in reset
//   send         one-cycle command strobe to snd_cmd
//   cmd_start    command ROM start address (valid with send)
//   cmd_len      command length (valid with send)
//   init_done    all init commands acknowledged
//   busy         sequencer not idle
//   err          sticky: a command exhausted its retries
module bt_cmd_seq
    import bt_pkg::*;
#(
    parameter int unsigned NUM_INIT    = 2,
    parameter int unsigned NUM_BTN     = 2,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned PWRUP_CYC   = 131072,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned MAX_RETRY   = 2,
    parameter logic [NUM_INIT*ADDR_W-1:0] INIT_START = {ADDR_W'(INIT1_START), ADDR_W'(INIT0_START)},
    parameter logic [NUM_INIT*LEN_W-1:0]  INIT_LEN   = {LEN_W'(INIT1_LEN), LEN_W'(INIT0_LEN)},
    parameter logic [NUM_BTN*ADDR_W-1:0]  BTN_START  = {ADDR_W'(CMD_PREV), ADDR_W'(CMD_NEXT)},
    parameter logic [NUM_BTN*LEN_W-1:0]   BTN_LEN    = {LEN_W'(CMD_BTN_LEN), LEN_W'(CMD_BTN_LEN)}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_rel,
    input  logic               resp_rcvd,
    output logic               cmd_n,
    output logic               send,
    output logic [ADDR_W-1:0]  cmd_start,
    output logic [LEN_W-1:0]   cmd_len,
    output logic               init_done,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CNT_W  = width_of(PWRUP_CYC);
    localparam int unsigned TIM_W  = width_of(TIMEOUT_CYC);
    localparam int unsigned RTY_W  = width_of(MAX_RETRY + 1);
    localparam int unsigned IIDX_W = width_of(NUM_INIT);
    localparam int unsigned BIDX_W = width_of(NUM_BTN);

    localparam logic [CNT_W-1:0]  PWR_LAST  = CNT_W'(PWRUP_CYC - 1);
    localparam logic [TIM_W-1:0]  TO_LAST   = TIM_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [IIDX_W-1:0] INIT_LAST = IIDX_W'(NUM_INIT - 1);

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [TIM_W-1:0]    timer, timer_d;
    logic [RTY_W-1:0]    retry, retry_d;
    logic [IIDX_W-1:0]   idx, idx_d;
    logic                cmd_n_d, send_d, init_done_d, err_d;
    logic [ADDR_W-1:0]   cmd_start_d;
    logic [LEN_W-1:0]    cmd_len_d;
    logic                take, pend_any;
    logic [BIDX_W-1:0]   gnt_idx;

    bt_req_arb #(
        .NUM_BTN (NUM_BTN),
        .IDX_W   (BIDX_W)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_rel  (btn_rel),
        .set_en   (init_done),
        .take     (take),
        .pend_any (pend_any),
        .gnt_idx  (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWRUP;
            cnt       <= '0;
            timer     <= '0;
            retry     <= '0;
            idx       <= '0;
            cmd_n     <= 1'b1;
            send      <= 1'b0;
            cmd_start <= '0;
            cmd_len   <= '0;
            init_done <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            timer     <= timer_d;
            retry     <= retry_d;
            idx       <= idx_d;
            cmd_n     <= cmd_n_d;
            send      <= send_d;
            cmd_start <= cmd_start_d;
            cmd_len   <= cmd_len_d;
            init_done <= init_done_d;
            busy      <= (state_d != IDLE);
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        timer_d     = timer;
        retry_d     = retry;
        idx_d       = idx;
        cmd_n_d     = cmd_n;
        send_d      = 1'b0;
        cmd_start_d = cmd_start;
        cmd_len_d   = cmd_len;
        init_done_d = init_done;
        err_d       = err;
        take        = 1'b0;

        case (state)
            PWRUP: begin
                if (cnt == PWR_LAST) begin
                    state_d = BOOT;
                    cmd_n_d = 1'b0;
                    timer_d = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            BOOT: begin
                if (resp_rcvd) begin
                    state_d = INIT_SEND;
                    idx_d   = '0;
                    retry_d = '0;
                end else if (timer == TO_LAST) begin
                    state_d = FAIL;
                    cmd_n_d = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            INIT_SEND: begin
                state_d = INIT_WAIT;
                timer_d = timer + 1'b1;
            end
            INIT_WAIT: begin
                if (resp_rcvd) begin
                    retry_d = '0;
                    if (idx == INIT_LAST) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = INIT_SEND;
                    end
                end else if (timer == TO_LAST) begin
                    if (retry < RTY_MAX) begin
                        retry_d = retry + 1'b1;
                        state_d = INIT_SEND;
                    end else begin
                        err_d   = 1'b1;
                        cmd_n_d = 1'b1;
                        state_d = FAIL;
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            IDLE: begin
                if (pend_any) begin
                    take    = 1'b1;
                    retry_d = '0;
                    state_d = BTN_SEND;
                end
            end
            BTN_SEND: begin
                state_d = BTN_WAIT;
                timer_d = timer + 1'b1;
            end
            BTN_WAIT: begin
                if (resp_rcvd) begin
                    state_d = IDLE;
                end else if (timer == TO_LAST) begin
                    if (retry < RTY_MAX) begin
                        retry_d = retry + 1'b1;
                        state_d = BTN_SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            FAIL: begin
                cmd_n_d = 1'b1;
            end
            default: begin
                state_d = FAIL;
                cmd_n_d = 1'b1;
            end
        endcase

        // Timer is zero during the send cycle, so sends on timeout are
        // TIMEOUT_CYC cycles apart. Button retries reuse the held command.
        if (state_d == INIT_SEND) begin
            send_d  = 1'b1;
            timer_d = '0;
            for (int unsigned i = 0; i < NUM_INIT; i++) begin
                if (idx_d == IIDX_W'(i)) begin
                    cmd_start_d = INIT_START[i*ADDR_W +: ADDR_W];
                    cmd_len_d   = INIT_LEN[i*LEN_W +: LEN_W];
                end
            end
        end else if (state_d == BTN_SEND) begin
            send_d  = 1'b1;
            timer_d = '0;
            if (take) begin
                for (int unsigned i = 0; i < NUM_BTN; i++) begin
                    if (gnt_idx == BIDX_W'(i)) begin
                        cmd_start_d = BTN_START[i*ADDR_W +: ADDR_W];
                        cmd_len_d   = BTN_LEN[i*LEN_W +: LEN_W];
                    end
                end
            end
        end
    end

endmodule
